// File: rtl/jesd204_rx_block_sync_64b_if.sv
// Beat bus for the 64b/66b block aligner.
//   in_valid/in_data/in_header   : gearbox beat into the aligner
//   out_valid/out_data/out_header: same beat, one clk later, to the lane datapath
//   block_sync, bitslip          : alignment status and slip request
//   status_state, status_slip_cnt: debug view of the aligner FSM and slip counter
// Handshake: there is no back-pressure. A beat is transferred on every clk edge
// where in_valid is high; beats with in_valid low carry no meaning and are not
// evaluated. out_valid follows the same rule one cycle later.
// master = beat source / status consumer, slave = aligner.
interface jesd204_rx_block_sync_64b_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_header;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_header;
  logic        block_sync;
  logic        bitslip;
  logic [1:0]  status_state;
  logic [7:0]  status_slip_cnt;

  modport master (
    output in_valid, in_data, in_header,
    input  out_valid, out_data, out_header,
    input  block_sync, bitslip, status_state, status_slip_cnt
  );

  modport slave (
    input  in_valid, in_data, in_header,
    output out_valid, out_data, out_header,
    output block_sync, bitslip, status_state, status_slip_cnt
  );
endinterface

// File: rtl/jesd204_rx_block_sync_64b.sv
// 64b/66b sync-header block aligner for one JESD204C RX lane.
// Hunts for a window of SH_CNT_MAX consecutive valid sync headers (01/10),
// slipping the gearbox one bit on every bad header, then monitors the lock and
// drops it when SH_INVALID_MAX bad headers land in one window.
// Ports:
//   clk   : lane clock
//   reset : synchronous, active-high
//   bus   : beat in/out, block_sync, bitslip and status (see the interface file)
module jesd204_rx_block_sync_64b #(
  parameter int unsigned SH_CNT_MAX     = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  jesd204_rx_block_sync_64b_if.slave   bus
);

  localparam int SHW  = $clog2(SH_CNT_MAX + 1);
  localparam int INVW = $clog2(SH_INVALID_MAX + 1);
  localparam int WW   = $clog2(SLIP_WAIT + 1);

  localparam logic [SHW-1:0]  SH_LAST   = SHW'(SH_CNT_MAX);
  localparam logic [INVW-1:0] INV_LAST  = INVW'(SH_INVALID_MAX);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  sh_q, sh_d, sh_inc;
  logic [INVW-1:0] inv_q, inv_d, inv_inc;
  logic [WW-1:0]   wait_q, wait_d;
  logic [7:0]      slip_q, slip_d, slip_inc;
  logic            bitslip_q, bitslip_d;
  logic            sync_q, sync_d;
  logic            hdr_ok;

  // Pass-through register stage, deliberately independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_header <= '0;
    end else begin
      bus.out_valid  <= bus.in_valid;
      bus.out_data   <= bus.in_data;
      bus.out_header <= bus.in_header;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      sh_q      <= '0;
      inv_q     <= '0;
      wait_q    <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      inv_q     <= inv_d;
      wait_q    <= wait_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      sync_q    <= sync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    inv_d     = inv_q;
    wait_d    = wait_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    sync_d    = sync_q;

    hdr_ok   = bus.in_header[1] ^ bus.in_header[0];
    sh_inc   = sh_q + 1'b1;
    inv_inc  = inv_q + {{(INVW-1){1'b0}}, ~hdr_ok};
    // Slip counter saturates so a lane that never locks still reads 255.
    slip_inc = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;

    case (state_q)
      ST_HUNT: begin
        if (bus.in_valid) begin
          if (hdr_ok) begin
            if (sh_inc == SH_LAST) begin
              state_d = ST_LOCKED;
              sync_d  = 1'b1;
              sh_d    = '0;
              inv_d   = '0;
            end else begin
              sh_d = sh_inc;
            end
          end else begin
            state_d   = ST_SLIP_WAIT;
            bitslip_d = 1'b1;
            slip_d    = slip_inc;
            sh_d      = '0;
            inv_d     = '0;
            wait_d    = '0;
          end
        end
      end

      // Give the gearbox time to settle after a slip; input is ignored here.
      // SLIP_WAIT >= 1 also keeps bitslip from firing on back-to-back cycles.
      ST_SLIP_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_HUNT;
          wait_d  = '0;
          sh_d    = '0;
          inv_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_LOCKED: begin
        if (bus.in_valid) begin
          // Loss of lock wins over a window end on the same beat.
          if (inv_inc == INV_LAST) begin
            state_d   = ST_SLIP_WAIT;
            sync_d    = 1'b0;
            bitslip_d = 1'b1;
            slip_d    = slip_inc;
            sh_d      = '0;
            inv_d     = '0;
            wait_d    = '0;
          end else if (sh_inc == SH_LAST) begin
            sh_d  = '0;
            inv_d = '0;
          end else begin
            sh_d  = sh_inc;
            inv_d = inv_inc;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
        sync_d  = 1'b0;
        sh_d    = '0;
        inv_d   = '0;
        wait_d  = '0;
      end
    endcase
  end

  assign bus.block_sync      = sync_q;
  assign bus.bitslip         = bitslip_q;
  assign bus.status_state    = state_q;
  assign bus.status_slip_cnt = slip_q;

endmodule
